// File: rtl/wdt_kick_pkg.sv
// wdt_kick_pkg
// Shared definitions for the watchdog kick controller: controller states,
// error codes, the two unlock key values and a small index helper.
// Ports: none (package).
// Configuration: the optional early-kick window check in wdt_kick_ctrl is
// enabled by defining WDT_KICK_WINDOW_EN; nothing in this package depends on it.

package wdt_kick_pkg;

   localparam int KEY_W = 16;

   localparam logic [KEY_W-1:0] KEY1 = 16'h5A5A;
   localparam logic [KEY_W-1:0] KEY2 = 16'hA5A5;

   localparam logic [15:0] KICK_CNT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_KEY2 = 2'd1,
      CLEAR     = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_KEY   = 2'd1,
      ERR_TMO   = 2'd2,
      ERR_EARLY = 2'd3
   } err_code_e;

   // Next requester index after idx, wrapping at n (n need not be a power of two).
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/wdt_kick_ctrl_rr_arb.sv
// wdt_rr_arb
// Round-robin pick among NREQ level requests, searching upward from ptr_i
// and wrapping; purely combinational.
// Ports:
//   req_i   [NREQ]   request levels
//   ptr_i   [IDX_W]  index with highest priority this cycle
//   gnt_o   [NREQ]   one-hot winner (all zero when nobody requests)
//   idx_o   [IDX_W]  winner index (0 when nobody requests)
//   valid_o          at least one request present

module wdt_rr_arb #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   // One extra bit so ptr + offset cannot overflow before the wrap.
   localparam int CW = IDX_W + 1;

   logic [CW-1:0]    cand_wide;
   logic [IDX_W-1:0] cand;

   // Walk the candidates in priority order; the first requester found wins.
   always_comb begin
      gnt_o     = '0;
      idx_o     = '0;
      valid_o   = 1'b0;
      cand_wide = '0;
      cand      = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand_wide = {1'b0, ptr_i} + CW'(i);
         if (cand_wide >= CW'(NREQ)) begin
            cand_wide = cand_wide - CW'(NREQ);
         end
         cand = cand_wide[IDX_W-1:0];
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wdt_kick_ctrl.sv
// wdt_kick_ctrl
// Sequences two-key watchdog refreshes from NREQ requesters onto the single
// counter-clear input. A requester wins the round-robin in IDLE with KEY1,
// then must present KEY2 within KEY_TMO cycles; the following cycle emits a
// one-cycle clear pulse. Failures produce a one-cycle error pulse plus a held
// code and requester index.
// Configuration macro: WDT_KICK_WINDOW_EN -- when defined, a KEY2 arriving
// while counter_value_i < win_min_i is rejected with ERR_EARLY.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   en_i                   controller enable
//   req_i   [NREQ]         kick request levels
//   key_i   [NREQ][16]     key words, valid while the matching req_i is set
//   gnt_o   [NREQ]         one-hot, key of that requester sampled this cycle
//   counter_value_i [32]   live watchdog counter
//   win_min_i [32]         minimum counter value for a legal kick
//   clear_o                one-cycle clear pulse
//   busy_o                 transaction in progress
//   err_o                  one-cycle error pulse
//   err_code_o [2]         code of last error (held)
//   err_id_o [clog2(NREQ)] requester of last error (held)
//   kick_cnt_o [16]        successful kicks, saturating

module wdt_kick_ctrl
   import wdt_kick_pkg::*;
#(
   parameter  int NREQ    = 4,
   parameter  int TMO_W   = 8,
   parameter  int KEY_TMO = 64,
   localparam int IDX_W   = $clog2(NREQ)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       en_i,
   input  logic [NREQ-1:0]            req_i,
   input  logic [NREQ-1:0][KEY_W-1:0] key_i,
   output logic [NREQ-1:0]            gnt_o,
   input  logic [31:0]                counter_value_i,
   input  logic [31:0]                win_min_i,
   output logic                       clear_o,
   output logic                       busy_o,
   output logic                       err_o,
   output logic [1:0]                 err_code_o,
   output logic [IDX_W-1:0]           err_id_o,
   output logic [15:0]                kick_cnt_o
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [IDX_W-1:0] rr_q, rr_d;
   logic             clear_q, clear_d;
   logic             err_q, err_d;
   err_code_e        err_code_q, err_code_d;
   logic [IDX_W-1:0] err_id_q, err_id_d;
   logic [15:0]      kick_cnt_q, kick_cnt_d;

   logic             owner_err;
   err_code_e        owner_err_code;

   logic [NREQ-1:0]  arb_req;
   logic [NREQ-1:0]  arb_gnt;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_valid;

   // Arbitration is only meaningful when a new transaction may start.
   assign arb_req = (en_i && (state_q == IDLE)) ? req_i : '0;

   wdt_rr_arb #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req_i   (arb_req),
      .ptr_i   (rr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

`ifndef WDT_KICK_WINDOW_EN
   logic unused_window;
   assign unused_window = ^{counter_value_i, win_min_i};
`endif

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      tmo_d          = tmo_q;
      rr_d           = rr_q;
      clear_d        = 1'b0;
      err_d          = 1'b0;
      err_code_d     = err_code_q;
      err_id_d       = err_id_q;
      kick_cnt_d     = kick_cnt_q;
      gnt_o          = '0;
      owner_err      = 1'b0;
      owner_err_code = ERR_NONE;

      case (state_q)
         IDLE: begin
            if (en_i && arb_valid) begin
               gnt_o = arb_gnt;
               if (key_i[arb_idx] == KEY1) begin
                  owner_d = arb_idx;
                  tmo_d   = TMO_W'(KEY_TMO);
                  state_d = WAIT_KEY2;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ERR_KEY;
                  err_id_d   = arb_idx;
                  rr_d       = IDX_W'(wrap_inc(int'(arb_idx), NREQ));
               end
            end
         end

         WAIT_KEY2: begin
            if (!en_i) begin
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q - TMO_W'(1);
               // An owner request is checked before the timeout so a KEY2
               // landing on the last allowed cycle still succeeds.
               if (req_i[owner_q]) begin
                  gnt_o[owner_q] = 1'b1;
                  if (key_i[owner_q] == KEY2) begin
`ifdef WDT_KICK_WINDOW_EN
                     if (counter_value_i < win_min_i) begin
                        owner_err      = 1'b1;
                        owner_err_code = ERR_EARLY;
                     end else begin
                        clear_d = 1'b1;
                        state_d = CLEAR;
                     end
`else
                     clear_d = 1'b1;
                     state_d = CLEAR;
`endif
                  end else begin
                     owner_err      = 1'b1;
                     owner_err_code = ERR_KEY;
                  end
               end else if (tmo_q <= TMO_W'(1)) begin
                  owner_err      = 1'b1;
                  owner_err_code = ERR_TMO;
               end
            end
         end

         CLEAR: begin
            // The pulse already left with clear_q; an en_i drop here does not cancel it.
            if (kick_cnt_q != KICK_CNT_MAX) begin
               kick_cnt_d = kick_cnt_q + 16'd1;
            end
            rr_d    = IDX_W'(wrap_inc(int'(owner_q), NREQ));
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Every failure of an owned transaction reports the owner and moves
      // round-robin priority past it.
      if (owner_err) begin
         err_d      = 1'b1;
         err_code_d = owner_err_code;
         err_id_d   = owner_q;
         rr_d       = IDX_W'(wrap_inc(int'(owner_q), NREQ));
         state_d    = IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         tmo_q      <= '0;
         rr_q       <= '0;
         clear_q    <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         err_id_q   <= '0;
         kick_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         tmo_q      <= tmo_d;
         rr_q       <= rr_d;
         clear_q    <= clear_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         err_id_q   <= err_id_d;
         kick_cnt_q <= kick_cnt_d;
      end
   end

   assign clear_o    = clear_q;
   assign busy_o     = (state_q != IDLE);
   assign err_o      = err_q;
   assign err_code_o = err_code_q;
   assign err_id_o   = err_id_q;
   assign kick_cnt_o = kick_cnt_q;

endmodule

// File: tb/tb_wdt_kick_ctrl.sv
// tb_wdt_kick_ctrl
// Self-checking bench for wdt_kick_ctrl (NREQ=4, KEY_TMO=64). A transaction-
// level model (absolute deadlines, integer kick count) predicts every output
// each cycle; directed sequences add literal expectations at key points.
// Honours WDT_KICK_WINDOW_EN for the early-kick expectations.

module tb_wdt_kick_ctrl;

   localparam int NREQ = 4;
   localparam int TMO  = 64;
   localparam logic [15:0] K1 = 16'h5A5A;
   localparam logic [15:0] K2 = 16'hA5A5;
`ifdef WDT_KICK_WINDOW_EN
   localparam bit WINDOW_ON = 1'b1;
`else
   localparam bit WINDOW_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic [3:0]       req = '0;
   logic [3:0][15:0] key = '0;
   logic [31:0]      cntVal = '0;
   logic [31:0]      winMin = '0;

   logic [3:0]       gnt;
   logic             clear;
   logic             busy;
   logic             err;
   logic [1:0]       errCode;
   logic [1:0]       errId;
   logic [15:0]      kickCnt;

   int checks = 0;
   int errors = 0;

   // model state
   bit modelValid = 1'b0;
   bit skipKick = 1'b0;
   int cyc = 0;
   int mPtr = 0;
   bit mActive = 1'b0;
   int mOwner = 0;
   int mDeadline = 0;
   bit mClearNow = 1'b0;
   bit eErr = 1'b0;
   int eCode = 0;
   int eId = 0;
   int eKicks = 0;

   wdt_kick_ctrl #(
      .NREQ    (NREQ),
      .TMO_W   (8),
      .KEY_TMO (TMO)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .en_i            (en),
      .req_i           (req),
      .key_i           (key),
      .gnt_o           (gnt),
      .counter_value_i (cntVal),
      .win_min_i       (winMin),
      .clear_o         (clear),
      .busy_o          (busy),
      .err_o           (err),
      .err_code_o      (errCode),
      .err_id_o        (errId),
      .kick_cnt_o      (kickCnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] keys4(input logic [15:0] k3, input logic [15:0] k2,
                                         input logic [15:0] k1, input logic [15:0] k0);
      return {k3, k2, k1, k0};
   endfunction

   // First requester at or after the priority pointer, -1 if none.
   function automatic int pickWinner();
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = (mPtr + k) % NREQ;
         if (req[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [3:0] expGnt();
      int w;
      if (!en || mClearNow) return 4'b0000;
      if (mActive) return req[mOwner] ? (4'b0001 << mOwner) : 4'b0000;
      w = pickWinner();
      return (w < 0) ? 4'b0000 : (4'b0001 << w);
   endfunction

   // Advance the model across the coming clock edge using this cycle's inputs.
   task automatic modelStep();
      bit fail;
      int code;
      int w;
      fail = 1'b0;
      code = 0;
      if (!rst_n) begin
         mPtr = 0; mActive = 1'b0; mClearNow = 1'b0;
         eErr = 1'b0; eCode = 0; eId = 0; eKicks = 0;
         modelValid = 1'b1;
         return;
      end
      eErr = 1'b0;
      if (mClearNow) begin
         eKicks = (eKicks >= 65535) ? 65535 : eKicks + 1;
         mPtr = (mOwner + 1) % NREQ;
         mClearNow = 1'b0;
      end else if (!en) begin
         mActive = 1'b0;
      end else if (mActive) begin
         if (req[mOwner]) begin
            if (key[mOwner] == K2) begin
               if (WINDOW_ON && (cntVal < winMin)) begin
                  fail = 1'b1; code = 3;
               end else begin
                  mClearNow = 1'b1; mActive = 1'b0;
               end
            end else begin
               fail = 1'b1; code = 1;
            end
         end else if (cyc == mDeadline) begin
            fail = 1'b1; code = 2;
         end
         if (fail) begin
            eErr = 1'b1; eCode = code; eId = mOwner;
            mPtr = (mOwner + 1) % NREQ;
            mActive = 1'b0;
         end
      end else begin
         w = pickWinner();
         if (w >= 0) begin
            if (key[w] == K1) begin
               mActive = 1'b1; mOwner = w; mDeadline = cyc + TMO;
            end else begin
               eErr = 1'b1; eCode = 1; eId = w;
               mPtr = (w + 1) % NREQ;
            end
         end
      end
   endtask

   // Compare every cycle on the falling edge, then step the model.
   initial begin
      forever begin
         @(negedge clk);
         if (modelValid) begin
            checkOutput("gnt", gnt, expGnt());
            checkOutput("clear", clear, mClearNow);
            checkOutput("busy", busy, mActive || mClearNow);
            checkOutput("err", err, eErr);
            checkOutput("err_code", errCode, eCode);
            checkOutput("err_id", errId, eId);
            if (!skipKick) checkOutput("kick_cnt", kickCnt, eKicks);
         end
         modelStep();
         cyc++;
      end
   end

   task automatic applyWindowStimulus(input logic e, input logic [3:0] r, input logic [63:0] k,
                                      input logic [31:0] c, input logic [31:0] w);
      @(posedge clk);
      #1;
      rst_n = 1'b1; en = e; req = r; key = k; cntVal = c; winMin = w;
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic e, input logic [3:0] r, input logic [63:0] k);
      applyWindowStimulus(e, r, k, cntVal, winMin);
   endtask

   task automatic applyReset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         rst_n = 1'b0; en = 1'b0; req = '0; key = '0;
         @(negedge clk);
      end
   endtask

   // One complete kick by requester r (assumed to win arbitration alone).
   task automatic kick(input int r);
      logic [63:0] k1v;
      logic [63:0] k2v;
      k1v = '0; k2v = '0;
      k1v[r*16 +: 16] = K1;
      k2v[r*16 +: 16] = K2;
      applyStimulus(1'b1, 4'b0001 << r, k1v);
      applyStimulus(1'b1, 4'b0001 << r, k2v);
      applyStimulus(1'b1, 4'b0000, 64'd0);
      checkOutput("kick_clear", clear, 1'b1);
      applyStimulus(1'b1, 4'b0000, 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [3:0]       mask;
      logic [3:0][15:0] kv;

      applyReset(2);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_clear", clear, 1'b0);
      checkOutput("rst_err_code", errCode, 2'd0);
      checkOutput("rst_kick", kickCnt, 16'd0);

      // single kick by requester 0
      applyStimulus(1'b1, 4'b0001, keys4(16'h0, 16'h0, 16'h0, K1));
      checkOutput("t1_gnt_key1", gnt, 4'b0001);
      checkOutput("t1_busy0", busy, 1'b0);
      applyStimulus(1'b1, 4'b0001, keys4(16'h0, 16'h0, 16'h0, K2));
      checkOutput("t1_gnt_key2", gnt, 4'b0001);
      checkOutput("t1_busy1", busy, 1'b1);
      checkOutput("t1_noclear", clear, 1'b0);
      applyStimulus(1'b1, 4'b0000, 64'd0);
      checkOutput("t1_clear", clear, 1'b1);
      applyStimulus(1'b1, 4'b0000, 64'd0);
      checkOutput("t1_clear_off", clear, 1'b0);
      checkOutput("t1_kick", kickCnt, 16'd1);

      // mid-run reset returns counters to zero
      applyReset(1);
      applyStimulus(1'b1, 4'b0000, 64'd0);
      checkOutput("rst2_kick", kickCnt, 16'd0);

      // all four requesting: grant order 0,1,2,3
      for (int i = 0; i < 4; i++) begin
         mask = 4'hF << i;
         kv = {4{K1}};
         applyStimulus(1'b1, mask, kv);
         checkOutput("rr_gnt_key1", gnt, 32'd1 << i);
         kv[i] = K2;
         applyStimulus(1'b1, mask, kv);
         checkOutput("rr_gnt_key2", gnt, 32'd1 << i);
         kv = {4{K1}};
         applyStimulus(1'b1, mask & ~(4'b0001 << i), kv);
         checkOutput("rr_clear", clear, 1'b1);
         checkOutput("rr_gnt_in_clear", gnt, 4'b0000);
      end
      applyStimulus(1'b1, 4'b0000, 64'd0);
      checkOutput("rr_kick4", kickCnt, 16'd4);

      // requester 2 goes silent after KEY1
      applyStimulus(1'b1, 4'b0100, keys4(16'h0, K1, 16'h0, 16'h0));
      checkOutput("tmo_gnt", gnt, 4'b0100);
      for (int i = 0; i < TMO; i++) applyStimulus(1'b1, 4'b0000, 64'd0);
      checkOutput("tmo_busy_last", busy, 1'b1);
      checkOutput("tmo_no_err_yet", err, 1'b0);
      applyStimulus(1'b1, 4'b0000, 64'd0);
      checkOutput("tmo_err", err, 1'b1);
      checkOutput("tmo_code", errCode, 2'd2);
      checkOutput("tmo_id", errId, 2'd2);
      checkOutput("tmo_busy", busy, 1'b0);
      checkOutput("tmo_noclear", clear, 1'b0);
      applyStimulus(1'b1, 4'b0000, 64'd0);
      checkOutput("tmo_err_pulse", err, 1'b0);
      checkOutput("tmo_code_held", errCode, 2'd2);

      // bad KEY1 from requester 1, then requester 2 is next in line
      applyStimulus(1'b1, 4'b0010, keys4(16'h0, 16'h0, 16'h1234, 16'h0));
      checkOutput("badk1_gnt", gnt, 4'b0010);
      applyStimulus(1'b1, 4'b0111, keys4(16'h0, K1, K1, K1));
      checkOutput("badk1_err", err, 1'b1);
      checkOutput("badk1_code", errCode, 2'd1);
      checkOutput("badk1_id", errId, 2'd1);
      checkOutput("badk1_busy", busy, 1'b0);
      checkOutput("badk1_next", gnt, 4'b0100);
      applyStimulus(1'b1, 4'b0100, keys4(16'h0, K2, 16'h0, 16'h0));
      applyStimulus(1'b1, 4'b0000, 64'd0);
      checkOutput("badk1_clear", clear, 1'b1);

      // early-kick window: counter below minimum, then above
      applyWindowStimulus(1'b1, 4'b0001, keys4(16'h0, 16'h0, 16'h0, K1), 32'd500, 32'd1000);
      checkOutput("win_gnt", gnt, 4'b0001);
      applyWindowStimulus(1'b1, 4'b0001, keys4(16'h0, 16'h0, 16'h0, K2), 32'd500, 32'd1000);
      applyWindowStimulus(1'b1, 4'b0000, 64'd0, 32'd500, 32'd1000);
`ifdef WDT_KICK_WINDOW_EN
      checkOutput("win_early_err", err, 1'b1);
      checkOutput("win_early_code", errCode, 2'd3);
      checkOutput("win_early_id", errId, 2'd0);
      checkOutput("win_early_noclear", clear, 1'b0);
`else
      checkOutput("win_ignored_clear", clear, 1'b1);
      checkOutput("win_ignored_noerr", err, 1'b0);
`endif
      applyWindowStimulus(1'b1, 4'b0000, 64'd0, 32'd1500, 32'd1000);
      applyStimulus(1'b1, 4'b0010, keys4(16'h0, 16'h0, K1, 16'h0));
      checkOutput("win_ok_gnt", gnt, 4'b0010);
      applyStimulus(1'b1, 4'b0010, keys4(16'h0, 16'h0, K2, 16'h0));
      applyStimulus(1'b1, 4'b0000, 64'd0);
      checkOutput("win_ok_clear", clear, 1'b1);

      // enable drop while waiting for KEY2
      applyStimulus(1'b1, 4'b0100, keys4(16'h0, K1, 16'h0, 16'h0));
      checkOutput("endrop_gnt", gnt, 4'b0100);
      applyStimulus(1'b0, 4'b0100, keys4(16'h0, K2, 16'h0, 16'h0));
      checkOutput("endrop_gnt0", gnt, 4'b0000);
      applyStimulus(1'b1, 4'b0000, 64'd0);
      checkOutput("endrop_idle", busy, 1'b0);
      checkOutput("endrop_noerr", err, 1'b0);
      checkOutput("endrop_noclear", clear, 1'b0);

      // enable drop on the clear cycle still completes the pulse
      applyStimulus(1'b1, 4'b0100, keys4(16'h0, K1, 16'h0, 16'h0));
      applyStimulus(1'b1, 4'b0100, keys4(16'h0, K2, 16'h0, 16'h0));
      applyStimulus(1'b0, 4'b0000, 64'd0);
      checkOutput("endrop_clear_completes", clear, 1'b1);
      applyStimulus(1'b1, 4'b0000, 64'd0);

      // KEY2 on the last allowed cycle wins over the timeout
      applyStimulus(1'b1, 4'b1000, keys4(K1, 16'h0, 16'h0, 16'h0));
      checkOutput("late_gnt", gnt, 4'b1000);
      for (int i = 0; i < TMO - 1; i++) applyStimulus(1'b1, 4'b0000, 64'd0);
      applyStimulus(1'b1, 4'b1000, keys4(K2, 16'h0, 16'h0, 16'h0));
      checkOutput("late_gnt_key2", gnt, 4'b1000);
      applyStimulus(1'b1, 4'b0000, 64'd0);
      checkOutput("late_clear", clear, 1'b1);
      checkOutput("late_noerr", err, 1'b0);

      // wrong second key from the owner
      applyStimulus(1'b1, 4'b0001, keys4(16'h0, 16'h0, 16'h0, K1));
      applyStimulus(1'b1, 4'b0001, keys4(16'h0, 16'h0, 16'h0, 16'h1111));
      applyStimulus(1'b1, 4'b0000, 64'd0);
      checkOutput("badk2_err", err, 1'b1);
      checkOutput("badk2_code", errCode, 2'd1);
      checkOutput("badk2_id", errId, 2'd0);
      checkOutput("badk2_busy", busy, 1'b0);

      // kick counter saturation, preloaded near the top
      @(posedge clk);
      #1;
      skipKick = 1'b1;
      force dut.kick_cnt_q = 16'hFFFE;
      eKicks = 16'hFFFE;
      en = 1'b1; req = '0; key = '0;
      @(negedge clk);
      @(posedge clk);
      #1;
      release dut.kick_cnt_q;
      skipKick = 1'b0;
      @(negedge clk);
      kick(1);
      checkOutput("sat_kick_ffff", kickCnt, 16'hFFFF);
      kick(2);
      checkOutput("sat_kick_stays", kickCnt, 16'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
